pipe_skid_stage: RTL and testbench

//   Registered pipeline stage with valid/ready handshake and a one-entry skid buffer.
//   It is the consumer side of the plain enable register. The downstream reader's
//   out_ready drives backpressure, and the stage converts it into a registered in_ready
//   for the upstream writer. Sits between CPU pipeline stages (e.g. fetch->decode) to

---
 rtl/pipe_skid_stage.sv | 118 +++++++++++
 tb/tb_pipe_skid_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Registered valid/ready pipeline stage with a one-entry skid buffer; in_ready and out_valid come straight from flops.
// Optional stall statistics counter enabled by defining PIPE_SKID_STATS_EN.
module pipe_skid_stage #(
  parameter int unsigned            WIDTH     = 8,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic             clkrst_core_clk,
  input  logic             clkrst_core_rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             in_fire, out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = in_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
        end else if (in_fire) begin
          skid_d  = in_data;
          state_d = FULL;
        end
      end
      FULL: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end
    // Handshake flags are registered copies of the next state so no input reaches an output.
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      state_q     <= EMPTY;
      main_q      <= RESET_VAL;
      skid_q      <= RESET_VAL;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign out_data  = main_q;
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;

`ifdef PIPE_SKID_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: directed literal checks plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_pipe_skid_stage;

  localparam int unsigned WIDTH = 8;
  localparam logic [WIDTH-1:0] RST_V = 8'h00;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
`ifdef PIPE_SKID_STATS_EN
  logic [15:0]      stall_cnt;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  pipe_skid_stage #(.WIDTH(WIDTH), .RESET_VAL(RST_V)) dut (
    .clkrst_core_clk(clk),
    .clkrst_core_rst(rst),
    .flush(flush),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef PIPE_SKID_STATS_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the stage is a FIFO of depth 2; out_data shows the head,
  // or the last delivered value when empty (RST_V after reset/flush).
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] mlast = RST_V;

  always @(posedge clk) begin
    automatic bit fin  = in_valid && (mq.size() < 2);
    automatic bit fout = out_ready && (mq.size() > 0);
    if (rst || flush) begin
      mq.delete();
      mlast = RST_V;
    end else begin
      if (fout) mlast = mq.pop_front();
      if (fin) mq.push_back(in_data);
    end
  end

  logic             prev_ov = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  always @(negedge clk) begin
    chk("out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
    chk("in_ready", {31'd0, in_ready}, {31'd0, (mq.size() < 2)});
    chk("out_data", {24'd0, out_data}, {24'd0, (mq.size() > 0) ? mq[0] : mlast});
    if (prev_ov && !out_ready && !flush && !rst) begin
      chk("stable_valid", {31'd0, out_valid}, 32'd1);
      chk("stable_data", {24'd0, out_data}, {24'd0, prev_data});
    end
    prev_ov   = out_valid;
    prev_data = out_data;
  end

  task automatic cyc(input logic v, input logic [WIDTH-1:0] d, input logic ordy, input logic fl);
    #1;
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(negedge clk);
  endtask

  task automatic chk_out(input string name, input logic ov, input logic ir, input logic [WIDTH-1:0] od);
    chk({name, "_ov"}, {31'd0, out_valid}, {31'd0, ov});
    chk({name, "_ir"}, {31'd0, in_ready}, {31'd0, ir});
    chk({name, "_od"}, {24'd0, out_data}, {24'd0, od});
  endtask

  initial begin
    logic [WIDTH-1:0] hold_d;
    logic             hold_v;

    // 1: reset held two cycles, then released
    rst = 1'b1;
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk_out("rst1", 1'b0, 1'b1, 8'h00);
    cyc(1'b1, 8'h66, 1'b1, 1'b0);
    chk_out("rst2", 1'b0, 1'b1, 8'h00);
    #1 rst = 1'b0;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk_out("post_rst", 1'b0, 1'b1, 8'h00);

    // 2: back-to-back stream with out_ready high
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, i[WIDTH-1:0], 1'b1, 1'b0);
      chk_out("stream", 1'b1, 1'b1, i[WIDTH-1:0]);
    end
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk_out("stream_end", 1'b0, 1'b1, 8'h10);

    // 3: fill skid under backpressure, then drain
    cyc(1'b1, 8'hA1, 1'b0, 1'b0);
    chk_out("busy_a1", 1'b1, 1'b1, 8'hA1);
    cyc(1'b1, 8'hA2, 1'b0, 1'b0);
    chk_out("full_a1", 1'b1, 1'b0, 8'hA1);
    cyc(1'b1, 8'hA2, 1'b1, 1'b0);
    chk_out("drain_a2", 1'b1, 1'b1, 8'hA2);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk_out("drain_empty", 1'b0, 1'b1, 8'hA2);

    // 4: flush while full with a pending input
    cyc(1'b1, 8'hB1, 1'b0, 1'b0);
    cyc(1'b1, 8'hB2, 1'b0, 1'b0);
    chk_out("full_b1", 1'b1, 1'b0, 8'hB1);
    cyc(1'b1, 8'hB3, 1'b0, 1'b1);
    chk_out("flush", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      chk_out("post_flush", 1'b0, 1'b1, 8'h00);
    end
    cyc(1'b1, 8'hC1, 1'b1, 1'b0);
    chk_out("accept_after_flush", 1'b1, 1'b1, 8'hC1);

    // 5: random traffic; upstream holds its offer while the model says not ready
    hold_v = 1'b0;
    hold_d = '0;
    for (int i = 0; i < 1000; i++) begin
      logic v;
      logic [WIDTH-1:0] d;
      if (hold_v && mq.size() >= 2) begin
        v = 1'b1;
        d = hold_d;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        d = WIDTH'($urandom);
      end
      hold_v = v;
      hold_d = d;
      cyc(v, d, ($urandom_range(0, 2) != 0), ($urandom_range(0, 63) == 0));
    end

`ifdef PIPE_SKID_STATS_EN
    // 6: saturation of the stall counter, flush keeps it, reset clears it
    cyc(1'b1, 8'hD1, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
    end
    chk("stall_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("stall_flush", {16'd0, stall_cnt}, 32'h0000_FFFF);
    #1 rst = 1'b1;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("stall_rst", {16'd0, stall_cnt}, 32'h0000_0000);
    #1 rst = 1'b0;
`endif

    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
